// File: rtl/spi_frame_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_frame_pkg : shared types and constants for the SPI frame path
// Rev 1.0
// ------------------------------------------------------------------
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_OP   = 3'd1,
    GET_ADDR = 3'd2,
    GET_LEN  = 3'd3,
    GET_DATA = 3'd4,
    GET_CSUM = 3'd5,
    DRAIN    = 3'd6
  } state_t;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_CLEAR_ERR = 8'h02;
  localparam logic       STATUS_MARK  = 1'b1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_sync_edge : N-stage synchroniser with rise/fall detection
// Rev 1.0
// ------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sh;
  logic              r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh   <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sh   <= {r_sh[STAGES-2:0], din};
      r_prev <= r_sh[STAGES-1];
    end
  end

  assign sync = r_sh[STAGES-1];
  assign rise = sync & ~r_prev;
  assign fall = ~sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_frame_ctrl : SPI byte framing, command parsing and write strobes
// Rev 1.0
// ------------------------------------------------------------------
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MAX_LEN     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck_in,
  input  logic              cs_n_in,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              slave_reset,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic w_sck_rise, w_sck_sync_unused, w_sck_fall_unused;
  logic w_cs_sync, w_cs_fall, w_cs_rise_unused;
  logic w_byte_valid;
  logic [7:0] w_status;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_xor;
  logic [7:0]        r_remaining;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_sticky;
  logic              r_last_ok;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .reset(reset),
    .din  (sck_in),
    .sync (w_sck_sync_unused),
    .rise (w_sck_rise),
    .fall (w_sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .reset(reset),
    .din  (cs_n_in),
    .sync (w_cs_sync),
    .rise (w_cs_rise_unused),
    .fall (w_cs_fall)
  );

  // The slave's shift register is complete by the 8th synchronised rising edge,
  // so the byte is consumed straight from rx_byte on that clock.
  assign w_byte_valid = w_sck_rise && (r_bit_cnt == 3'd7) && !w_cs_sync;
  assign w_status     = {STATUS_MARK, r_last_ok, r_err_sticky, err_count[4:0]};
  assign slave_reset  = reset | w_cs_sync;
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
    end else if (w_cs_sync) begin
      r_bit_cnt <= 3'd0;
    end else if (w_sck_rise) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      tx_byte      <= 8'h80;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_count    <= 8'h00;
      r_err_sticky <= 1'b0;
      r_last_ok    <= 1'b0;
      r_xor        <= 8'h00;
      r_remaining  <= 8'h00;
      r_addr       <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (w_byte_valid) tx_byte <= w_status;

      if (w_cs_sync) begin
        // Deselect mid-frame is an abort; a byte arriving together with it is dropped.
        if (r_state inside {GET_ADDR, GET_LEN, GET_DATA, GET_CSUM}) begin
          r_err_sticky <= 1'b1;
          err_count    <= sat_inc(err_count);
        end
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (w_cs_fall) r_state <= GET_OP;
          GET_OP: if (w_byte_valid) begin
            r_xor <= rx_byte;
            if (rx_byte == OP_WRITE) begin
              r_state <= GET_ADDR;
            end else begin
              if (rx_byte == OP_CLEAR_ERR) begin
                r_err_sticky <= 1'b0;
              end else begin
                r_err_sticky <= 1'b1;
                err_count    <= sat_inc(err_count);
              end
              r_state <= DRAIN;
            end
          end
          GET_ADDR: if (w_byte_valid) begin
            r_addr  <= ADDR_W'(rx_byte);
            r_xor   <= r_xor ^ rx_byte;
            r_state <= GET_LEN;
          end
          GET_LEN: if (w_byte_valid) begin
            r_xor <= r_xor ^ rx_byte;
            if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
              r_err_sticky <= 1'b1;
              err_count    <= sat_inc(err_count);
              r_state      <= DRAIN;
            end else begin
              r_remaining <= rx_byte;
              r_state     <= GET_DATA;
            end
          end
          GET_DATA: if (w_byte_valid) begin
            wr_en       <= 1'b1;
            wr_addr     <= r_addr;
            wr_data     <= rx_byte;
            r_addr      <= r_addr + ADDR_W'(1);
            r_xor       <= r_xor ^ rx_byte;
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= GET_CSUM;
          end
          GET_CSUM: if (w_byte_valid) begin
            frame_done <= 1'b1;
            frame_ok   <= (rx_byte == r_xor);
            r_last_ok  <= (rx_byte == r_xor);
            if (rx_byte != r_xor) begin
              r_err_sticky <= 1'b1;
              err_count    <= sat_inc(err_count);
            end
            r_state <= DRAIN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
